sdram_aref_sched: RTL and testbench
===================================

Name: sdram_aref_sched

Overview:
Parametrised successor to the single-shot SDRAM auto-refresh engine. It tracks refresh debt and lets the arbiter postpone refreshes up to a programmable limit, as JEDEC allows. Once granted, it issues PRECHARGE-all followed by a burst of back-to-back AUTO REFRESH commands. It sits beside the read/write engines and drives the command mux through the arbiter's grant.

Parameters:
SDRAMMHZ, 100, controller clock in MHz; NsPerCyc = ceil(1000/SDRAMMHZ).
SDRAMLINE, 2048, rows per refresh period; also sets the address width ADDRW = $clog2(SDRAMLINE), minimum 11.
TREFMS, 64, refresh period in ms.
TRPNS, 20, tRP in ns; CYCRP = ceil(TRPNS/NsPerCyc).
TRFCNS, 70, tRFC in ns; CYCRFC = ceil(TRFCNS/NsPerCyc).
MAXPOSTPONE, 8, maximum outstanding refreshes (1..8); DW = $clog2(MAXPOSTPONE+1).
TREFIOVR, 0, tREFI override in cycles when nonzero. When 0, CYCREFI = floor(TREFMS*1e6/SDRAMLINE/NsPerCyc), which is 3125 at the defaults.

Ports:
Clk  in  1  controller clock.
Rest  in  1  synchronous active-high reset.
ArefEn  in  1  requests allowed; tick counting continues while low.
BusGrant  in  1  arbiter grant for the command bus.
ArefReq  out  1  refresh wanted (debt>0, IDLE, ArefEn).
ArefUrgent  out  1  debt == MAXPOSTPONE; arbiter must grant next.
ArefBusy  out  1  engine owns the bus.
ArefCmd  out  4  `NOPC / `PRECHAGE / `AUTOREF from define.v.
ArefAddr  out  ADDRW  bit 10 = 1 during the PRECHARGE cycle, 0 otherwise.
ArefDone  out  1  one-cycle pulse at the end of each tRFC.
ArefDebt  out  DW  outstanding refresh count.
ArefOvf  out  1  sticky: a refresh was lost.

Behaviour:
- Clock and reset: one clock, Clk. Reset Rest is synchronous and active-high.
- Reset values:
  - State is IDLE and all counters are 0.
  - ArefCmd is `NOPC and all other outputs are 0.
  - Reset mid-sequence aborts immediately and returns to IDLE. The next cycle's command is NOPC.
- Interval counter:
  - Counts 0..CYCREFI-1 and wraps.
  - A tick occurs on the wrap cycle; each tick increments the debt.
  - If debt is already MAXPOSTPONE at a tick, debt holds and ArefOvf sets.
- Simultaneous tick and Done: the debt is unchanged (net +1-1).
- Debt arithmetic is saturating at both ends: it never goes below 0 and never above MAXPOSTPONE.
- IDLE:
  - ArefReq = (debt != 0) && ArefEn.
  - If ArefReq and BusGrant are both high in the same cycle, move to PREC next cycle and raise ArefBusy.
  - BusGrant without ArefReq is ignored.
- PREC:
  - Cycle 0: ArefCmd = `PRECHAGE and ArefAddr[10] = 1.
  - Cycles 1..CYCRP: ArefCmd = NOPC.
  - After cycle CYCRP, go to AREF.
- AREF:
  - Cycle 0: ArefCmd = `AUTOREF.
  - Cycles 1..CYCRFC: ArefCmd = NOPC.
  - In cycle CYCRFC, ArefDone pulses and the debt decrements.
  - Next state is AREF (cycle 0) if BusGrant is high and the post-decrement debt != 0. No precharge is repeated in this case.
  - Otherwise next state is IDLE and ArefBusy drops.
- BusGrant falling mid-sequence does not abort; the current refresh completes and no further burst follows.
- ArefEn falling mid-sequence has the same effect as BusGrant falling.
- Latency from grant to first AUTOREF is 1+CYCRP+1 cycles: grant in cycle g gives PRECHARGE at g+1 and AUTOREF at g+2+CYCRP.
- ArefUrgent is combinational from debt and is independent of ArefEn.

Optional Feature:
SDRAM_AREF_STAT_EN
- Defined: adds output ArefCntTot (32 bit, wraps), which increments on each ArefDone. Also adds ArefMaxDebt (DW bits), the high-water mark of debt. Both clear on Rest.
- Undefined: these ports and registers are absent, and all other behaviour is identical.

Decomposition:
- Shared package/define.v:
  - State encodings SDAREFIDLE/SDAREFPREC/SDAREFAREF (existing).
  - Command codes NOPC/PRECHAGE/AUTOREF.
  - New helper constants for the A10 bit index (10).
- One sub-module: sdram_aref_timer. It holds the tREFI interval counter and tick output, plus the debt counter with saturation and overflow. The top level keeps the FSM and command outputs.

Test Plan:
1. Debt and urgency:
   - Stimulus: TREFIOVR=20, MAXPOSTPONE=4, ArefEn=1, BusGrant=0 for 100 cycles.
   - Required: debt = 1, 2, 3, 4 at ticks 20, 40, 60, 80; ArefUrgent high from tick 80; ArefOvf=0 until tick 100, where it sets and debt holds at 4.
2. Single refresh:
   - Stimulus: defaults with TREFIOVR=20, debt=1, one-cycle BusGrant at cycle g.
   - Required: PRECHAGE with Addr[10]=1 at g+1; AUTOREF at g+4; ArefDone at g+11; Busy low at g+12; debt=0.
3. Burst:
   - Stimulus: debt=3, BusGrant held high.
   - Required: one PRECHAGE followed by three AUTOREFs spaced 8 cycles apart (CYCRFC+1); debt ends at 0.
4. Grant drop:
   - Stimulus: debt=3, BusGrant drops during the first tRFC.
   - Required: exactly one AUTOREF; return to IDLE; debt=2; ArefReq high again.
5. Tick coincident with Done:
   - Stimulus: a tick lands in the same cycle as ArefDone.
   - Required: debt unchanged.
6. Reset mid-operation:
   - Stimulus: Rest pulsed high during PREC.
   - Required: next cycle ArefCmd=NOPC, Busy=0, debt=0, Ovf=0; with SDRAM_AREF_STAT_EN defined, the stat counters also read 0.

Source files
------------

// File: rtl/sdram_aref_sched_pkg.sv
// Shared encodings for the SDRAM auto-refresh scheduler: FSM states, SDRAM
// command codes {CS_n,RAS_n,CAS_n,WE_n}, the A10 bit index and a ceil-div helper.
package sdram_aref_sched_pkg;

  typedef enum logic [1:0] {
    SDAREFIDLE = 2'd0,
    SDAREFPREC = 2'd1,
    SDAREFAREF = 2'd2
  } aref_state_e;

  localparam logic [3:0] NOPC     = 4'b0111;
  localparam logic [3:0] PRECHAGE = 4'b0010;
  localparam logic [3:0] AUTOREF  = 4'b0001;

  // A10 high during PRECHARGE selects all banks.
  localparam int A10_BIT = 10;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/sdram_aref_timer.sv
// tREFI interval counter plus the saturating refresh-debt counter with a
// sticky overflow flag; debt_nx_o is the value debt takes at the next edge.
module sdram_aref_timer #(
  parameter int CYCREFI     = 3125,
  parameter int MAXPOSTPONE = 8,
  parameter int DW          = 4,
  parameter int IW          = 12
) (
  input  logic          Clk,
  input  logic          Rest,
  input  logic          dec_i,
  output logic [DW-1:0] debt_o,
  output logic [DW-1:0] debt_nx_o,
  output logic          ovf_o
);

  localparam logic [IW-1:0] ILAST = IW'(CYCREFI - 1);
  localparam logic [DW-1:0] DMAX  = DW'(MAXPOSTPONE);

  logic [IW-1:0] icnt_q, icnt_d;
  logic [DW-1:0] debt_q, debt_d;
  logic          ovf_q, ovf_d;
  logic          tick;

  always_comb begin
    tick   = (icnt_q == ILAST);
    icnt_d = tick ? '0 : icnt_q + 1'b1;
    debt_d = debt_q;
    ovf_d  = ovf_q;
    // A tick and a completed refresh in the same cycle cancel out.
    if (tick && !dec_i) begin
      if (debt_q == DMAX) ovf_d = 1'b1;
      else                debt_d = debt_q + 1'b1;
    end else if (dec_i && !tick && (debt_q != '0)) begin
      debt_d = debt_q - 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rest) begin
      icnt_q <= '0;
      debt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      icnt_q <= icnt_d;
      debt_q <= debt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign debt_o    = debt_q;
  assign debt_nx_o = debt_d;
  assign ovf_o     = ovf_q;

endmodule

// File: rtl/sdram_aref_sched.sv
// SDRAM auto-refresh scheduler: postponable refresh debt, PRECHARGE-all then a
// burst of AUTO REFRESH while granted. Define SDRAM_AREF_STAT_EN for statistics.
module sdram_aref_sched
  import sdram_aref_sched_pkg::*;
#(
  parameter int SDRAMMHZ    = 100,
  parameter int SDRAMLINE   = 2048,
  parameter int TREFMS      = 64,
  parameter int TRPNS       = 20,
  parameter int TRFCNS      = 70,
  parameter int MAXPOSTPONE = 8,
  parameter int TREFIOVR    = 0,
  localparam int ADDRW = ($clog2(SDRAMLINE) < 11) ? 11 : $clog2(SDRAMLINE),
  localparam int DW    = $clog2(MAXPOSTPONE + 1)
) (
  input  logic             Clk,
  input  logic             Rest,
  input  logic             ArefEn,
  input  logic             BusGrant,
  output logic             ArefReq,
  output logic             ArefUrgent,
  output logic             ArefBusy,
  output logic [3:0]       ArefCmd,
  output logic [ADDRW-1:0] ArefAddr,
  output logic             ArefDone,
  output logic [DW-1:0]    ArefDebt,
  output logic             ArefOvf
`ifdef SDRAM_AREF_STAT_EN
  ,
  output logic [31:0]      ArefCntTot,
  output logic [DW-1:0]    ArefMaxDebt
`endif
);

  localparam int NS_PER_CYC = ceil_div(1000, SDRAMMHZ);
  localparam int CYCRP      = ceil_div(TRPNS, NS_PER_CYC);
  localparam int CYCRFC     = ceil_div(TRFCNS, NS_PER_CYC);
  localparam int CYCREFI    = (TREFIOVR != 0) ? TREFIOVR
                              : (TREFMS * 1000000) / SDRAMLINE / NS_PER_CYC;
  localparam int IW         = (CYCREFI > 1) ? $clog2(CYCREFI) : 1;
  localparam int CMAX       = (CYCRP > CYCRFC) ? CYCRP : CYCRFC;
  localparam int CW         = (CMAX < 1) ? 1 : $clog2(CMAX + 1);

  localparam logic [CW-1:0] RP_LAST  = CW'(CYCRP);
  localparam logic [CW-1:0] RFC_LAST = CW'(CYCRFC);
  localparam logic [DW-1:0] DMAX     = DW'(MAXPOSTPONE);

  aref_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    cmd_q;
  logic          a10_q;
  logic          busy_q;
  logic          done_q;
  logic          stop_q;
  logic [DW-1:0] debt;
  logic [DW-1:0] debt_nx;
  logic          ovf;
  logic          req;

  sdram_aref_timer #(
    .CYCREFI    (CYCREFI),
    .MAXPOSTPONE(MAXPOSTPONE),
    .DW         (DW),
    .IW         (IW)
  ) u_timer (
    .Clk      (Clk),
    .Rest     (Rest),
    .dec_i    (done_q),
    .debt_o   (debt),
    .debt_nx_o(debt_nx),
    .ovf_o    (ovf)
  );

  assign req = (state_q == SDAREFIDLE) && (debt != '0) && ArefEn;

  // stop_q remembers that grant or enable dropped, so the burst ends after
  // the refresh in flight.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      state_q <= SDAREFIDLE;
      cnt_q   <= '0;
      cmd_q   <= NOPC;
      a10_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      cmd_q  <= NOPC;
      a10_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        SDAREFIDLE: begin
          if (req && BusGrant) begin
            state_q <= SDAREFPREC;
            cnt_q   <= '0;
            cmd_q   <= PRECHAGE;
            a10_q   <= 1'b1;
            busy_q  <= 1'b1;
            stop_q  <= 1'b0;
          end
        end
        SDAREFPREC: begin
          if (!BusGrant || !ArefEn) stop_q <= 1'b1;
          if (cnt_q == RP_LAST) begin
            state_q <= SDAREFAREF;
            cnt_q   <= '0;
            cmd_q   <= AUTOREF;
            done_q  <= (CYCRFC == 0);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SDAREFAREF: begin
          if (cnt_q == RFC_LAST) begin
            if (BusGrant && ArefEn && !stop_q && (debt_nx != '0)) begin
              cnt_q  <= '0;
              cmd_q  <= AUTOREF;
              done_q <= (CYCRFC == 0);
            end else begin
              state_q <= SDAREFIDLE;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
            end
          end else begin
            if (!BusGrant || !ArefEn) stop_q <= 1'b1;
            cnt_q  <= cnt_q + 1'b1;
            done_q <= ((cnt_q + 1'b1) == RFC_LAST);
          end
        end
        default: begin
          state_q <= SDAREFIDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          stop_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ArefAddr          = '0;
    ArefAddr[A10_BIT] = a10_q;
  end

  assign ArefReq    = req;
  assign ArefUrgent = (debt == DMAX);
  assign ArefBusy   = busy_q;
  assign ArefCmd    = cmd_q;
  assign ArefDone   = done_q;
  assign ArefDebt   = debt;
  assign ArefOvf    = ovf;

`ifdef SDRAM_AREF_STAT_EN
  logic [31:0]   tot_q;
  logic [DW-1:0] max_q;

  always_ff @(posedge Clk) begin
    if (Rest) begin
      tot_q <= '0;
      max_q <= '0;
    end else begin
      if (done_q) tot_q <= tot_q + 32'd1;
      if (debt_nx > max_q) max_q <= debt_nx;
    end
  end

  assign ArefCntTot  = tot_q;
  assign ArefMaxDebt = max_q;
`endif

endmodule

// File: tb/tb_sdram_aref_sched.sv
// Directed bench for sdram_aref_sched: a fast-tick instance (tREFI=20, max 4)
// and a slow-tick instance (tREFI=40, max 8) share clock and inputs.
module tb_sdram_aref_sched;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;

  // clock / reset / inputs
  logic Clk = 1'b0;
  logic Rest = 1'b1;
  logic ArefEn = 1'b0;
  logic BusGrant = 1'b0;
  always #5 Clk = ~Clk;

  logic        f_req, f_urg, f_busy, f_done, f_ovf;
  logic [3:0]  f_cmd;
  logic [10:0] f_addr;
  logic [2:0]  f_debt;
  logic        l_req, l_urg, l_busy, l_done, l_ovf;
  logic [3:0]  l_cmd;
  logic [10:0] l_addr;
  logic [3:0]  l_debt;
`ifdef SDRAM_AREF_STAT_EN
  logic [31:0] f_tot, l_tot;
  logic [2:0]  f_max;
  logic [3:0]  l_max;
`endif

  sdram_aref_sched #(.TREFIOVR(20), .MAXPOSTPONE(4)) u_fast (
    .Clk(Clk), .Rest(Rest), .ArefEn(ArefEn), .BusGrant(BusGrant),
    .ArefReq(f_req), .ArefUrgent(f_urg), .ArefBusy(f_busy), .ArefCmd(f_cmd),
    .ArefAddr(f_addr), .ArefDone(f_done), .ArefDebt(f_debt), .ArefOvf(f_ovf)
`ifdef SDRAM_AREF_STAT_EN
    , .ArefCntTot(f_tot), .ArefMaxDebt(f_max)
`endif
  );

  sdram_aref_sched #(.TREFIOVR(40), .MAXPOSTPONE(8)) u_long (
    .Clk(Clk), .Rest(Rest), .ArefEn(ArefEn), .BusGrant(BusGrant),
    .ArefReq(l_req), .ArefUrgent(l_urg), .ArefBusy(l_busy), .ArefCmd(l_cmd),
    .ArefAddr(l_addr), .ArefDone(l_done), .ArefDebt(l_debt), .ArefOvf(l_ovf)
`ifdef SDRAM_AREF_STAT_EN
    , .ArefCntTot(l_tot), .ArefMaxDebt(l_max)
`endif
  );

  int n_tot = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_pre = 0;
  int n_aref = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // driver tasks: cycle k is the state seen #1 after the k-th edge since reset
  task automatic step();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    Rest = 1'b1;
    step();
    step();
    Rest = 1'b0;
    cyc = 0;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  // scoreboard on the slow instance: every AUTOREF must match the next expected cycle
  task automatic mon_step();
    step();
    if (l_cmd == C_PRE) n_pre++;
    if (l_cmd == C_REF) begin
      n_aref++;
      if (exp_q.size() != 0) check("l_aref_cycle", 32'(cyc), exp_q.pop_front());
      else                   check("l_aref_extra", 32'(cyc), 32'd0);
    end
  endtask

  task automatic mon_to(input int n);
    while (cyc < n) mon_step();
  endtask

  initial begin
    // Debt and urgency
    ArefEn = 1'b1;
    do_reset();
    check("rst_cmd", f_cmd, C_NOP);
    check("rst_busy", f_busy, 0);
    check("rst_debt", f_debt, 0);
    check("rst_req", f_req, 0);
    check("rst_urg", f_urg, 0);
    check("rst_ovf", f_ovf, 0);
    check("rst_done", f_done, 0);
    check("rst_addr", f_addr, 0);
    run_to(19);  check("debt_c19", f_debt, 0);
    run_to(20);  check("debt_c20", f_debt, 1); check("req_c20", f_req, 1);
    run_to(40);  check("debt_c40", f_debt, 2);
    run_to(60);  check("debt_c60", f_debt, 3);
    run_to(79);  check("debt_c79", f_debt, 3); check("urg_c79", f_urg, 0);
    run_to(80);  check("debt_c80", f_debt, 4); check("urg_c80", f_urg, 1);
    run_to(99);  check("ovf_c99", f_ovf, 0);
    run_to(100); check("ovf_c100", f_ovf, 1); check("debt_c100", f_debt, 4);
`ifdef SDRAM_AREF_STAT_EN
    check("stat_max_c100", f_max, 4);
    check("stat_tot_c100", f_tot, 0);
`endif

    // Reset during PREC
    BusGrant = 1'b1;
    step();
    BusGrant = 1'b0;
    check("r6_pre_cmd", f_cmd, C_PRE);
    check("r6_busy", f_busy, 1);
    Rest = 1'b1;
    step();
    Rest = 1'b0;
    cyc = 0;
    check("r6_cmd", f_cmd, C_NOP);
    check("r6_busy0", f_busy, 0);
    check("r6_debt", f_debt, 0);
    check("r6_ovf", f_ovf, 0);
    check("r6_urg", f_urg, 0);
`ifdef SDRAM_AREF_STAT_EN
    check("r6_stat_tot", f_tot, 0);
    check("r6_stat_max", f_max, 0);
`endif
    run_to(3);
    check("r6_cmd_c3", f_cmd, C_NOP);
    check("r6_busy_c3", f_busy, 0);

    // Single refresh, grant at cycle 20
    do_reset();
    run_to(20);
    check("s_req_g", f_req, 1);
    BusGrant = 1'b1;
    step();
    BusGrant = 1'b0;
    check("s_cmd_g1", f_cmd, C_PRE);
    check("s_a10_g1", f_addr[10], 1);
    check("s_busy_g1", f_busy, 1);
    check("s_req_g1", f_req, 0);
    run_to(22); check("s_cmd_g2", f_cmd, C_NOP); check("s_a10_g2", f_addr[10], 0);
    run_to(23); check("s_cmd_g3", f_cmd, C_NOP);
    run_to(24); check("s_cmd_g4", f_cmd, C_REF); check("s_busy_g4", f_busy, 1);
    run_to(30); check("s_done_g10", f_done, 0);
    run_to(31); check("s_done_g11", f_done, 1); check("s_debt_g11", f_debt, 1);
    run_to(32);
    check("s_busy_g12", f_busy, 0);
    check("s_debt_g12", f_debt, 0);
    check("s_done_g12", f_done, 0);
    check("s_cmd_g12", f_cmd, C_NOP);
`ifdef SDRAM_AREF_STAT_EN
    check("s_stat_tot", f_tot, 1);
`endif

    // Tick coincident with Done: grant at 28, done at 39 = tick cycle
    do_reset();
    run_to(28);
    check("t_debt_c28", f_debt, 1);
    BusGrant = 1'b1;
    step();
    BusGrant = 1'b0;
    check("t_cmd_c29", f_cmd, C_PRE);
    run_to(32); check("t_cmd_c32", f_cmd, C_REF);
    run_to(39); check("t_done_c39", f_done, 1); check("t_debt_c39", f_debt, 1);
    run_to(40);
    check("t_debt_c40", f_debt, 1);
    check("t_busy_c40", f_busy, 0);
    check("t_req_c40", f_req, 1);

    // Burst on slow instance: debt 3 at cycle 120, grant held
    do_reset();
    run_to(120);
    check("b_debt_c120", l_debt, 3);
    n_pre = 0;
    n_aref = 0;
    exp_q.push_back(32'd124);
    exp_q.push_back(32'd132);
    exp_q.push_back(32'd140);
    BusGrant = 1'b1;
    mon_to(148);
    check("b_debt_c148", l_debt, 0);
    check("b_busy_c148", l_busy, 0);
    mon_to(155);
    BusGrant = 1'b0;
    check("b_pre_count", n_pre, 1);
    check("b_aref_count", n_aref, 3);
    check("b_exp_left", exp_q.size(), 0);

    // Grant drop during first tRFC
    do_reset();
    run_to(120);
    n_pre = 0;
    n_aref = 0;
    exp_q.delete();
    exp_q.push_back(32'd124);
    BusGrant = 1'b1;
    mon_to(126);
    BusGrant = 1'b0;
    mon_to(131);
    check("g_done_c131", l_done, 1);
    mon_to(132);
    check("g_busy_c132", l_busy, 0);
    check("g_debt_c132", l_debt, 2);
    check("g_req_c132", l_req, 1);
    check("g_cmd_c132", l_cmd, C_NOP);
    mon_to(140);
    check("g_aref_count", n_aref, 1);
    check("g_pre_count", n_pre, 1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
